// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl - stall/flush control and cache-switch sequencer
// Optional macro PIPE_CTRL_PERF_EN adds stall/flush event counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES   = 2,
    parameter int SWITCH_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_busywait,
    input  logic       d_busywait,
    input  logic       branch_jump_signal,
    input  logic       ex_d_mem_r,
    input  logic [4:0] ex_write_address,
    input  logic [4:0] id_reg1_read_address,
    input  logic [4:0] id_reg2_read_address,
    input  logic       ex_switch_cache_w,
    input  logic       switch_ack,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       id_ex_stall,
    output logic       ex_mem_stall,
    output logic       mem_wb_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       switch_req,
    output logic       switch_busy,
    output logic       switch_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2,
        ST_RESUME = 2'd3
    } state_e;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);
    localparam logic [8:0] TMO_LIMIT  = 9'(SWITCH_TIMEOUT);

    state_e     state_q;
    logic [3:0] drain_cnt_q;
    logic [7:0] tmo_cnt_q;
    logic       switch_req_q;
    logic       switch_busy_q;
    logic       switch_err_q;

    logic       busy;
    logic       load_use;
    logic [8:0] tmo_cnt_inc;

    assign busy        = i_busywait | d_busywait;
    assign load_use    = ex_d_mem_r && (ex_write_address != 5'd0) &&
                         ((ex_write_address == id_reg1_read_address) ||
                          (ex_write_address == id_reg2_read_address));
    assign tmo_cnt_inc = {1'b0, tmo_cnt_q} + 9'd1;

    assign switch_req  = switch_req_q;
    assign switch_busy = switch_busy_q;
    assign switch_err  = switch_err_q;

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_stall  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_stall = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (busy) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                    mem_wb_stall = 1'b1;
                end else if (branch_jump_signal) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            ST_DRAIN: begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_stall = 1'b1;
                // A busy D-cache freezes the back end instead of bubbling it
                if (d_busywait) begin
                    ex_mem_stall = 1'b1;
                    mem_wb_stall = 1'b1;
                end else begin
                    ex_mem_flush = 1'b1;
                end
            end
            ST_SWITCH: begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_flush = 1'b1;
            end
            ST_RESUME: begin
                pc_stall    = i_busywait;
                if_id_stall = i_busywait;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            drain_cnt_q   <= 4'd0;
            tmo_cnt_q     <= 8'd0;
            switch_req_q  <= 1'b0;
            switch_busy_q <= 1'b0;
            switch_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_switch_cache_w && !busy) begin
                        state_q       <= ST_DRAIN;
                        drain_cnt_q   <= DRAIN_LOAD;
                        switch_busy_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Leave on the cycle whose decrement reaches zero
                    if (!d_busywait) begin
                        if (drain_cnt_q <= 4'd1) begin
                            state_q      <= ST_SWITCH;
                            drain_cnt_q  <= 4'd0;
                            tmo_cnt_q    <= 8'd0;
                            switch_req_q <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q - 4'd1;
                        end
                    end
                end
                ST_SWITCH: begin
                    if (switch_ack) begin
                        state_q      <= ST_RESUME;
                        tmo_cnt_q    <= 8'd0;
                        switch_req_q <= 1'b0;
                    end else if (tmo_cnt_inc == TMO_LIMIT) begin
                        state_q      <= ST_RESUME;
                        tmo_cnt_q    <= 8'd0;
                        switch_req_q <= 1'b0;
                        switch_err_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_inc[7:0];
                    end
                end
                ST_RESUME: begin
                    if (!i_busywait) begin
                        state_q       <= ST_RUN;
                        switch_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    assign stall_cycles_d = stall_cycles_q + {31'd0, pc_stall};
    assign flush_events_d = flush_events_q + {31'd0, (if_id_flush | id_ex_flush)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl - directed self-checking bench
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       i_busywait, d_busywait, branch_jump_signal, ex_d_mem_r;
    logic [4:0] ex_write_address, id_reg1_read_address, id_reg2_read_address;
    logic       ex_switch_cache_w, switch_ack;
    logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic       if_id_flush, id_ex_flush, ex_mem_flush;
    logic       switch_req, switch_busy, switch_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int errors = 0;
    int checks = 0;

    // {stalls pc..mem_wb, flushes if_id..ex_mem}
    localparam logic [7:0] O_IDLE = 8'b000_00_000;
    localparam logic [7:0] O_LU   = 8'b110_00_010;
    localparam logic [7:0] O_BUSY = 8'b111_11_000;
    localparam logic [7:0] O_BR   = 8'b000_00_110;
    localparam logic [7:0] O_FE   = 8'b111_00_001;
    localparam logic [7:0] O_DBSY = 8'b111_11_000;
    localparam logic [7:0] O_RSI  = 8'b110_00_000;

    logic [7:0]  outs;
    logic [10:0] stat;
    assign outs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                   if_id_flush, id_ex_flush, ex_mem_flush};
    assign stat = {outs, switch_req, switch_busy, switch_err};

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES  (2),
        .SWITCH_TIMEOUT(4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_busywait          (i_busywait),
        .d_busywait          (d_busywait),
        .branch_jump_signal  (branch_jump_signal),
        .ex_d_mem_r          (ex_d_mem_r),
        .ex_write_address    (ex_write_address),
        .id_reg1_read_address(id_reg1_read_address),
        .id_reg2_read_address(id_reg2_read_address),
        .ex_switch_cache_w   (ex_switch_cache_w),
        .switch_ack          (switch_ack),
        .pc_stall            (pc_stall),
        .if_id_stall         (if_id_stall),
        .id_ex_stall         (id_ex_stall),
        .ex_mem_stall        (ex_mem_stall),
        .mem_wb_stall        (mem_wb_stall),
        .if_id_flush         (if_id_flush),
        .id_ex_flush         (id_ex_flush),
        .ex_mem_flush        (ex_mem_flush),
        .switch_req          (switch_req),
        .switch_busy         (switch_busy),
        .switch_err          (switch_err)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles        (stall_cycles),
        .flush_events        (flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        i_busywait = 0; d_busywait = 0; branch_jump_signal = 0; ex_d_mem_r = 0;
        ex_write_address = 0; id_reg1_read_address = 0; id_reg2_read_address = 0;
        ex_switch_cache_w = 0; switch_ack = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        checks++;
        if (stat !== {O_IDLE, 3'b000}) begin
            errors++; $display("FAIL reset_state got %b want %b", stat, {O_IDLE, 3'b000});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (stat !== {O_IDLE, 3'b000}) begin
            errors++; $display("FAIL reset_release got %b want %b", stat, {O_IDLE, 3'b000});
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        ex_d_mem_r = 1; ex_write_address = 5; id_reg1_read_address = 3; id_reg2_read_address = 5;
        #1;
        checks++;
        if (outs !== O_LU) begin
            errors++; $display("FAIL load_use_reg2 got %b want %b", outs, O_LU);
        end
        ex_write_address = 0; id_reg2_read_address = 0;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            errors++; $display("FAIL load_use_x0 got %b want %b", outs, O_IDLE);
        end
        ex_write_address = 7; id_reg1_read_address = 7; id_reg2_read_address = 9;
        #1;
        checks++;
        if (outs !== O_LU) begin
            errors++; $display("FAIL load_use_reg1 got %b want %b", outs, O_LU);
        end
        ex_d_mem_r = 0;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            errors++; $display("FAIL no_load got %b want %b", outs, O_IDLE);
        end
        ex_d_mem_r = 1; branch_jump_signal = 1;
        #1;
        checks++;
        if (outs !== O_BR) begin
            errors++; $display("FAIL branch_over_load got %b want %b", outs, O_BR);
        end
        idle_inputs();
    endtask

    task automatic test_busy_branch();
        @(negedge clk);
        d_busywait = 1; branch_jump_signal = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (outs !== O_BUSY) begin
                errors++; $display("FAIL dbusy_cycle%0d got %b want %b", c, outs, O_BUSY);
            end
            @(negedge clk);
        end
        d_busywait = 0;
        #1;
        checks++;
        if (outs !== O_BR) begin
            errors++; $display("FAIL branch_after_busy got %b want %b", outs, O_BR);
        end
        branch_jump_signal = 0; i_busywait = 1;
        #1;
        checks++;
        if (outs !== O_BUSY) begin
            errors++; $display("FAIL ibusy got %b want %b", outs, O_BUSY);
        end
        idle_inputs();
    endtask

    task automatic test_switch_ack();
        logic [10:0] exp [7];
        exp[0] = {O_FE, 3'b010};   // DRAIN 1
        exp[1] = {O_FE, 3'b010};   // DRAIN 2
        exp[2] = {O_FE, 3'b110};   // SWITCH 1
        exp[3] = {O_FE, 3'b110};   // SWITCH 2
        exp[4] = {O_FE, 3'b110};   // SWITCH 3, ack driven
        exp[5] = {O_IDLE, 3'b010}; // RESUME
        exp[6] = {O_IDLE, 3'b000}; // RUN
        @(negedge clk);
        ex_switch_cache_w = 1;
        #1;
        checks++;
        if (stat !== {O_IDLE, 3'b000}) begin
            errors++; $display("FAIL switch_pre got %b want %b", stat, {O_IDLE, 3'b000});
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ex_switch_cache_w = (c == 3);   // second request mid-sequence is ignored
            switch_ack = (c == 4);
            #1;
            checks++;
            if (stat !== exp[c]) begin
                errors++; $display("FAIL switch_ack_c%0d got %b want %b", c + 1, stat, exp[c]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_switch_drain_busy();
        logic [10:0] exp [7];
        exp[0] = {O_DBSY, 3'b010}; // DRAIN, d-cache busy
        exp[1] = {O_FE, 3'b010};   // DRAIN, branch ignored
        exp[2] = {O_FE, 3'b010};   // DRAIN
        exp[3] = {O_FE, 3'b110};   // SWITCH, ack driven
        exp[4] = {O_RSI, 3'b010};  // RESUME, i-cache busy
        exp[5] = {O_IDLE, 3'b010}; // RESUME
        exp[6] = {O_IDLE, 3'b000}; // RUN
        @(negedge clk);
        ex_switch_cache_w = 1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            ex_switch_cache_w = 0;
            d_busywait = (c == 0);
            branch_jump_signal = (c == 1);
            switch_ack = (c == 3);
            i_busywait = (c == 4);
            #1;
            checks++;
            if (stat !== exp[c]) begin
                errors++; $display("FAIL switch_dbusy_c%0d got %b want %b", c + 1, stat, exp[c]);
            end
        end
        idle_inputs();
    endtask

    // ack_cycle < 0 means no ack is ever given
    task automatic test_switch_timeout(input int ack_cycle, input logic exp_err);
        logic [10:0] exp [8];
        exp[0] = {O_FE, 3'b010};
        exp[1] = {O_FE, 3'b010};
        exp[2] = {O_FE, 3'b110};
        exp[3] = {O_FE, 3'b110};
        exp[4] = {O_FE, 3'b110};
        exp[5] = {O_FE, 3'b110};
        exp[6] = {O_IDLE, 2'b01, exp_err};
        exp[7] = {O_IDLE, 2'b00, exp_err};
        @(negedge clk);
        ex_switch_cache_w = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            ex_switch_cache_w = 0;
            switch_ack = (c == ack_cycle);
            #1;
            checks++;
            if (stat !== exp[c]) begin
                errors++; $display("FAIL timeout_ack%0d_c%0d got %b want %b", ack_cycle, c + 1, stat, exp[c]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_err_sticky();
        repeat (3) @(negedge clk);
        ex_d_mem_r = 1; ex_write_address = 12; id_reg1_read_address = 12;
        #1;
        checks++;
        if (stat !== {O_LU, 3'b001}) begin
            errors++; $display("FAIL err_sticky got %b want %b", stat, {O_LU, 3'b001});
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_switch();
        @(negedge clk);
        ex_switch_cache_w = 1;
        repeat (3) @(negedge clk);
        ex_switch_cache_w = 0;
        #1;
        checks++;
        if (stat !== {O_FE, 3'b111}) begin
            errors++; $display("FAIL in_switch got %b want %b", stat, {O_FE, 3'b111});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (stat !== {O_IDLE, 3'b000}) begin
            errors++; $display("FAIL async_reset got %b want %b", stat, {O_IDLE, 3'b000});
        end
        #1 reset = 1'b0;
        @(negedge clk);
        ex_d_mem_r = 1; ex_write_address = 5; id_reg2_read_address = 5;
        #1;
        checks++;
        if (stat !== {O_LU, 3'b000}) begin
            errors++; $display("FAIL post_reset_lu got %b want %b", stat, {O_LU, 3'b000});
        end
        idle_inputs();
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        ex_d_mem_r = 1; ex_write_address = 5; id_reg2_read_address = 5;
        repeat (2) @(negedge clk);
        idle_inputs();
        branch_jump_signal = 1;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (stall_cycles !== 32'd2) begin
            errors++; $display("FAIL perf_stall got %0d want 2", stall_cycles);
        end
        checks++;
        if (flush_events !== 32'd3) begin
            errors++; $display("FAIL perf_flush got %0d want 3", flush_events);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_busy_branch();
        test_switch_ack();
        test_switch_drain_busy();
        test_switch_timeout(5, 1'b0);
        test_switch_timeout(-1, 1'b1);
        test_err_sticky();
        test_reset_mid_switch();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage RISC-V pipeline. Detects load-use hazards, propagates I-cache/D-cache busywait as a global stall, converts the EX-stage branch/jump decision into front-end flushes, and sequences the OS-initiated cache switch. The switch sequence drains the back end, hands off to the cache, and resumes fetch. It drives the stall and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
Parameters:
- DRAIN_CYCLES, 2, un-stalled bubble cycles needed to retire MEM and WB before a switch (1..15)
- SWITCH_TIMEOUT, 255, max SWITCH-state cycles waiting for switch_ack (1..255)

Ports:
- clk  input  1  single pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; returns block to RUN
- i_busywait  input  1  instruction cache stall request
- d_busywait  input  1  data cache stall request
- branch_jump_signal  input  1  EX-stage taken branch/jump
- ex_d_mem_r  input  1  instruction in EX is a load
- ex_write_address  input  5  destination register of EX instruction
- id_reg1_read_address, id_reg2_read_address  input  5 each  source registers of ID instruction
- ex_switch_cache_w  input  1  cache-switch instruction is in EX
- switch_ack  input  1  cache has completed the switch (one-cycle pulse)
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall  output  1 each  hold register
- if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  load bubble into register
- switch_req  output  1  level request to cache controller
- switch_busy  output  1  state is not RUN
- switch_err  output  1  sticky timeout flag

## Operation
- Stall and flush outputs are combinational from state and inputs. switch_req, switch_busy and switch_err are registered.
- FSM states: RUN, DRAIN, SWITCH, RESUME.
- RUN priority:
  - Global stall: busy = i_busywait|d_busywait. When busy, all five stall outputs are 1 and all flushes are 0. Pending flushes are suppressed while stalled; sources hold their signals.
  - Branch: branch_jump_signal & !busy → if_id_flush=1, id_ex_flush=1.
  - Load-use: ex_d_mem_r & ex_write_address≠0 & (ex_write_address==id_reg1_read_address | ex_write_address==id_reg2_read_address) & !busy & !branch_jump_signal → pc_stall=1, if_id_stall=1, id_ex_flush=1.
  - Switch: ex_switch_cache_w & !busy → go to DRAIN. The marker advances to MEM on the same edge. If branch_jump_signal is also 1, the branch flush applies and DRAIN is still entered.
- DRAIN:
  - pc_stall, if_id_stall and id_ex_stall are 1; ex_mem_flush is 1.
  - A 4-bit counter loads DRAIN_CYCLES on entry and decrements on each cycle with d_busywait=0.
  - While d_busywait=1, ex_mem_stall and mem_wb_stall are also 1 and ex_mem_flush is 0.
  - At count 0 → SWITCH.
- SWITCH:
  - Front end stays stalled and ex_mem_flush stays 1. switch_req=1.
  - An 8-bit timeout counter starts at 0 and increments each cycle.
  - switch_ack=1 → RESUME.
  - Counter reaching SWITCH_TIMEOUT without ack → switch_err set (sticky until reset), then RESUME.
  - If ack and timeout fall in the same cycle, ack wins and switch_err is not set.
- RESUME: pc_stall and if_id_stall stay 1 while i_busywait=1. With i_busywait=0, all stalls are 0 that cycle → RUN.
- Inputs other than reset and busywait are ignored outside RUN. A second ex_switch_cache_w during a sequence is not accepted.
- Reset (any state, mid-sequence included):
  - State → RUN; counters → 0.
  - switch_req=0, switch_busy=0, switch_err=0.
  - Stall/flush outputs follow RUN equations, so all are 0 with idle inputs.

## Timing
- Hazard, branch and busywait responses: 0-cycle latency, same cycle as the input.
- Switch sequence, with edge E1 the edge that accepts ex_switch_cache_w:
  - switch_busy rises at E1.
  - DRAIN lasts DRAIN_CYCLES cycles plus any d_busywait cycles.
  - switch_req rises on the edge entering SWITCH.
  - switch_ack is sampled on a rising edge; switch_req falls on that same edge.
  - Minimum total sequence is DRAIN_CYCLES+2 cycles (DRAIN, ≥1 SWITCH, 1 RESUME).
- switch_busy falls on the edge RESUME→RUN.
- Reset is asynchronous; outputs change without waiting for clk.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments each cycle pc_stall=1.
  - flush_events increments each cycle if_id_flush|id_ex_flush=1.
  - Both wrap at 2^32 and reset to 0.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Load x5 in EX (ex_write_address=5), ID reads x5 on reg2 → same cycle pc_stall=1, if_id_stall=1, id_ex_flush=1. Repeat with ex_write_address=0 → all 0.
- d_busywait=1 for 3 cycles with branch_jump_signal=1 → 3 cycles all stalls 1, flushes 0. Next cycle if_id_flush=id_ex_flush=1.
- ex_switch_cache_w=1, DRAIN_CYCLES=2, switch_ack on 3rd SWITCH cycle → switch_busy high 2+3+1=6 cycles, switch_req high 3 cycles, ex_mem_flush high during DRAIN and SWITCH.
- Switch with no ack, SWITCH_TIMEOUT=4 → switch_err=1 after 4 SWITCH cycles, then RESUME→RUN. switch_err stays 1 until reset.
- Reset asserted in SWITCH → switch_req, switch_busy and switch_err go 0 immediately. After release, a load-use hazard again gives RUN-state response.
- With PIPE_CTRL_PERF_EN: 2 load-use stalls + 1 branch → stall_cycles=2, flush_events=3.
